// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
// - uart_state_e : transmitter FSM state encoding
// - clks_per_bit : derives clocks per serial bit from clock and baud rate
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    // Integer division; callers must choose rates giving a result of at least 2.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit timing counter for the UART transmitter.
// Ports:
//   clk        : system clock, rising edge
//   rstn       : asynchronous active-low reset, clears the counter
//   load_i     : reload the counter at the start of a serial bit
//   tick_o     : high in the last clock of the current bit
//   pre_tick_o : high in the second-to-last clock of the current bit
module uart_bit_timer #(
    parameter int unsigned ClksPerBit = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic load_i,
    output logic tick_o,
    output logic pre_tick_o
);

    localparam int unsigned CntW = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] Reload = CntW'(ClksPerBit - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counts down to zero and parks there until the next load.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = Reload;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o     = (cnt_q == '0);
    assign pre_tick_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter fed from a first-word-fall-through FIFO.
// Pops one word whenever idle and enabled, then sends start, data (LSB first),
// optional parity and one or two stop bits.
// Ports:
//   clk          : system clock, rising edge
//   rstn         : asynchronous active-low reset
//   tx_en        : transmit enable, gates only the next pop
//   fifo_empty   : upstream FIFO empty flag
//   fifo_rd_data : upstream FIFO head word (FWFT)
//   fifo_rd_en   : one-cycle pop strobe (combinational)
//   txd          : serial line, idle high, registered
//   busy         : high from the pop cycle to the end of the last stop bit
//   frame_done   : one-cycle pulse in the final clock of the last stop bit
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  txd,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned BitCntW    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BitCntW-1:0] LastData = BitCntW'(DATA_WIDTH - 1);
    localparam logic [BitCntW-1:0] LastStop = BitCntW'(STOP_BITS - 1);

    uart_state_e           state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BitCntW-1:0]    bit_cnt_q;
    logic                  parity_q;
    logic                  txd_q;
    logic                  done_q;
    logic                  rdy_q;
    logic                  tick;
    logic                  pre_tick;
    logic                  timer_load;

    // rdy_q holds off the first pop until one clock after reset release.
    assign fifo_rd_en = rdy_q && (state_q == StIdle) && tx_en && !fifo_empty;
    assign busy       = (state_q != StIdle) || fifo_rd_en;
    assign txd        = txd_q;
    assign frame_done = done_q;
    assign timer_load = fifo_rd_en || (tick && (state_q != StIdle));

    uart_bit_timer #(
        .ClksPerBit(ClksPerBit)
    ) u_bit_timer (
        .clk       (clk),
        .rstn      (rstn),
        .load_i    (timer_load),
        .tick_o    (tick),
        .pre_tick_o(pre_tick)
    );

    // txd_q is loaded with the value of the bit being entered, so the line
    // changes on the same edge as the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
            done_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            rdy_q  <= 1'b1;
            done_q <= (state_q == StStop) && pre_tick && (bit_cnt_q == LastStop);
            unique case (state_q)
                StIdle: begin
                    if (fifo_rd_en) begin
                        shift_q   <= fifo_rd_data;
                        parity_q  <= (^fifo_rd_data) ^ (PARITY_ODD != 0);
                        bit_cnt_q <= '0;
                        txd_q     <= 1'b0;
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    if (tick) begin
                        txd_q     <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= '0;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (tick) begin
                        if (bit_cnt_q == LastData) begin
                            bit_cnt_q <= '0;
                            if (PARITY_EN != 0) begin
                                txd_q   <= parity_q;
                                state_q <= StParity;
                            end else begin
                                txd_q   <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            txd_q     <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (tick) begin
                        txd_q     <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= StStop;
                    end
                end
                StStop: begin
                    if (tick) begin
                        if (bit_cnt_q == LastStop) begin
                            state_q <= StIdle;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx at CLK_FREQ=40, BAUD_RATE=10 (4 clocks/bit).
// Four instances cover: no parity/1 stop, even parity, odd parity, 2 stop bits.
// Each has its own FIFO model; expected serial frames are pushed to a
// scoreboard when words are loaded and popped by a cycle model of the line.
module tb_fifo_uart_tx;

    localparam int NInst = 4;
    localparam int Cpb   = 4;
    localparam logic [3:0] PenV = 4'b0110;
    localparam logic [3:0] OddV = 4'b0100;
    localparam logic [3:0] Sb2V = 4'b1000;

    logic       clk;
    logic       rstn;
    logic       tx_en;
    logic       empty   [NInst];
    logic [7:0] rd_data [NInst];
    logic       rd_en   [NInst];
    logic       txd     [NInst];
    logic       busy    [NInst];
    logic       done    [NInst];

    // FIFO models and scoreboard (circular, 64 entries each)
    logic [7:0]  f_mem  [NInst][64];
    int          f_wr   [NInst];
    int          f_rd   [NInst];
    logic [11:0] sb_fb  [NInst][64];
    int          sb_wr  [NInst];
    int          sb_rd  [NInst];
    int          pops   [NInst];
    logic        pend   [NInst];
    int          k      [NInst];
    logic [11:0] cur_fb [NInst];
    logic        rel;
    int          n_pushed;
    int          n_checks;
    int          n_errors;

    fifo_uart_tx #(.CLK_FREQ(40), .BAUD_RATE(10), .DATA_WIDTH(8), .PARITY_EN(0),
                   .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rstn(rstn), .tx_en(tx_en), .fifo_empty(empty[0]),
        .fifo_rd_data(rd_data[0]), .fifo_rd_en(rd_en[0]), .txd(txd[0]),
        .busy(busy[0]), .frame_done(done[0]));
    fifo_uart_tx #(.CLK_FREQ(40), .BAUD_RATE(10), .DATA_WIDTH(8), .PARITY_EN(1),
                   .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .tx_en(tx_en), .fifo_empty(empty[1]),
        .fifo_rd_data(rd_data[1]), .fifo_rd_en(rd_en[1]), .txd(txd[1]),
        .busy(busy[1]), .frame_done(done[1]));
    fifo_uart_tx #(.CLK_FREQ(40), .BAUD_RATE(10), .DATA_WIDTH(8), .PARITY_EN(1),
                   .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rstn(rstn), .tx_en(tx_en), .fifo_empty(empty[2]),
        .fifo_rd_data(rd_data[2]), .fifo_rd_en(rd_en[2]), .txd(txd[2]),
        .busy(busy[2]), .frame_done(done[2]));
    fifo_uart_tx #(.CLK_FREQ(40), .BAUD_RATE(10), .DATA_WIDTH(8), .PARITY_EN(0),
                   .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rstn(rstn), .tx_en(tx_en), .fifo_empty(empty[3]),
        .fifo_rd_data(rd_data[3]), .fifo_rd_en(rd_en[3]), .txd(txd[3]),
        .busy(busy[3]), .frame_done(done[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Serial frame, first-sent bit in bit 0; unused upper bits are stop/idle ones.
    function automatic logic [11:0] frame_of(input logic [7:0] w, input logic pen,
                                             input logic odd);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = w;
        if (pen) f[9] = (^w) ^ odd;
        return f;
    endfunction

    function automatic int frame_len(input int i);
        return Cpb * (10 + int'(PenV[i]) + int'(Sb2V[i]));
    endfunction

    task automatic push_all(input logic [7:0] w);
        for (int i = 0; i < NInst; i++) begin
            f_mem[i][f_wr[i] % 64] = w;
            f_wr[i]++;
            sb_fb[i][sb_wr[i] % 64] = frame_of(w, PenV[i], OddV[i]);
            sb_wr[i]++;
        end
        n_pushed++;
    endtask

    always_comb begin
        for (int i = 0; i < NInst; i++) begin
            empty[i]   = (f_wr[i] == f_rd[i]);
            rd_data[i] = f_mem[i][f_rd[i] % 64];
        end
    end

    // FIFO pops land just after the edge the DUT sampled the head word on.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NInst; i++) begin
            if (pend[i]) begin
                f_rd[i]++;
                pops[i]++;
            end
        end
    end

    // Cycle model: k = clocks since pop (0 = idle); outputs compared as
    // {fifo_rd_en, busy, txd, frame_done} every cycle.
    always @(negedge clk) begin
        logic       exp_rd;
        logic [3:0] exp_v;
        logic [3:0] got_v;
        for (int i = 0; i < NInst; i++) begin
            exp_rd = (k[i] == 0) && tx_en && !empty[i] && rel && rstn;
            if (!rstn) begin
                exp_v = 4'b0010;
            end else if (k[i] == 0) begin
                exp_v = {exp_rd, exp_rd, 1'b1, 1'b0};
            end else begin
                exp_v = {1'b0, 1'b1, cur_fb[i][(k[i] - 1) / Cpb], k[i] == frame_len(i)};
            end
            got_v = {rd_en[i], busy[i], txd[i], done[i]};
            check_eq($sformatf("cycle_inst%0d", i), 32'(got_v), 32'(exp_v));
            pend[i] = rd_en[i];
            if (!rstn) begin
                k[i] = 0;
            end else if (k[i] == 0) begin
                if (exp_rd) begin
                    cur_fb[i] = sb_fb[i][sb_rd[i] % 64];
                    sb_rd[i]++;
                    k[i] = 1;
                end
            end else if (k[i] == frame_len(i)) begin
                k[i] = 0;
            end else begin
                k[i]++;
            end
        end
        rel = rstn;
    end

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int c = 0; c < 3000 && !idle; c++) begin
            @(posedge clk);
            #1;
            idle = 1'b1;
            for (int i = 0; i < NInst; i++) begin
                if (k[i] != 0 || f_wr[i] != f_rd[i]) idle = 1'b0;
            end
        end
        check_eq("idle_timeout", 32'(idle), 32'd1);
    endtask

    task automatic wait_k0(input int target);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(posedge clk);
            #1;
            if (k[0] == target) hit = 1'b1;
        end
        check_eq("reach_timeout", 32'(hit), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_pushed = 0;
        rel      = 1'b0;
        for (int i = 0; i < NInst; i++) begin
            f_wr[i]   = 0;
            f_rd[i]   = 0;
            sb_wr[i]  = 0;
            sb_rd[i]  = 0;
            pops[i]   = 0;
            pend[i]   = 1'b0;
            k[i]      = 0;
            cur_fb[i] = '1;
        end
        rstn  = 1'b0;
        tx_en = 1'b0;
        repeat (3) @(posedge clk);

        // Single frame 0xA5 on every configuration
        #1;
        rstn  = 1'b1;
        tx_en = 1'b1;
        push_all(8'hA5);
        wait_idle();

        // Back-to-back frames
        @(posedge clk);
        #1;
        push_all(8'h01);
        push_all(8'h80);
        push_all(8'hFF);
        wait_idle();

        // Drop tx_en during DATA of frame 1 with frame 2 queued
        @(posedge clk);
        #1;
        push_all(8'h3C);
        push_all(8'hC3);
        wait_k0(15);
        tx_en = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        for (int i = 0; i < NInst; i++) begin
            check_eq($sformatf("held_inst%0d", i), 32'(f_wr[i] - f_rd[i]), 32'd1);
        end
        tx_en = 1'b1;
        wait_idle();

        // Reset in data bit 3, then recovery
        @(posedge clk);
        #1;
        push_all(8'h5A);
        push_all(8'h96);
        wait_k0(18);
        #1;
        rstn = 1'b0;
        #1;
        for (int i = 0; i < NInst; i++) begin
            check_eq($sformatf("rst_txd_inst%0d", i), 32'(txd[i]), 32'd1);
            check_eq($sformatf("rst_busy_inst%0d", i), 32'(busy[i]), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        wait_idle();

        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < NInst; i++) begin
            check_eq($sformatf("pops_inst%0d", i), 32'(pops[i]), 32'(n_pushed));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
